memory_access_controller: RTL and testbench

Sequences every memory operation the microprogrammed control unit requests through its MOV/RW/MOC handshake. It converts one byte, halfword or word request from MAR/MDR into a series of single-byte accesses to the byte-wide RAM, with a programmable number of wait states per byte. It returns MOC when the request completes. It sits between the control unit/MAR/MDR and the RAM array.

---
 rtl/memory_access_controller_if.sv | 21 ++
 rtl/memory_access_controller.sv | 70 +++++++
 tb/tb_memory_access_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/memory_access_controller_if.sv
// memory_access_controller_if: control-unit request/response bundle plus the byte-wide RAM port.
interface memory_access_controller_if #(
    parameter int ADDR_W = 9
);
    logic              MOV, RW, Sign;
    logic [1:0]        Type;
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       DataIn, DataOut;
    logic              MOC, Err, Busy;
    logic              ram_cs, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata, ram_rdata;
    modport slave (
        input  MOV, RW, Type, Sign, Addr, DataIn, ram_rdata,
        output DataOut, MOC, Err, Busy, ram_cs, ram_we, ram_addr, ram_wdata
    );
    modport master (
        output MOV, RW, Type, Sign, Addr, DataIn, ram_rdata,
        input  DataOut, MOC, Err, Busy, ram_cs, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/memory_access_controller.sv
// memory_access_controller: splits byte/halfword/word requests into big-endian single-byte RAM accesses
// with WAIT_CYCLES extra cycles per byte, answering the control unit with MOC.
module memory_access_controller #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input logic                       Clk,
    input logic                       Clr,
    memory_access_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t            state, state_n;
    logic              rw, sign, err, bad, accept, act, commit, last;
    logic [1:0]        typ, k, last_k;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din, data_out, full, result;
    logic [23:0]       asm_q;
    logic [7:0]        wbyte;
    always_ff @(posedge Clk) state <= Clr ? IDLE : state_n;
    // A rejected request still spends one XFER cycle (with the RAM port idle) so MOC lands one edge after acceptance.
    always_comb begin
        bad     = bus.Type == 2'b11 || (bus.Type == 2'b01 && bus.Addr[0]) || (bus.Type == 2'b10 && bus.Addr[1:0] != 2'b00);
        accept  = state == IDLE && bus.MOV;
        act     = state == XFER && !err;
        commit  = act && cnt == 4'(WAIT_CYCLES);
        last_k  = typ == 2'b00 ? 2'd0 : typ == 2'b01 ? 2'd1 : 2'd3;
        last    = k == last_k;
        state_n = state;
        if (accept) state_n = XFER;
        else if ((state == XFER && err) || (commit && last)) state_n = DONE;
        else if (state == DONE && !bus.MOV) state_n = IDLE;
        full    = {asm_q, bus.ram_rdata};
        result  = typ == 2'b00 ? {{24{sign & full[7]}}, full[7:0]}
                : typ == 2'b01 ? {{16{sign & full[15]}}, full[15:0]} : full;
        wbyte   = 8'(din >> {last_k - k, 3'b000});
    end
    always_ff @(posedge Clk) begin
        if (Clr) begin
            {rw, sign, err, typ, k, cnt, addr, din, data_out, asm_q} <= '0;
        end else begin
            if (accept) begin
                rw   <= bus.RW;
                sign <= bus.Sign;
                typ  <= bus.Type;
                addr <= bus.Addr;
                din  <= bus.DataIn;
                err  <= bad;
                k    <= '0;
                cnt  <= '0;
            end
            if (act) begin
                cnt <= commit ? 4'd0 : cnt + 4'd1;
                k   <= commit ? k + 2'd1 : k;
            end
            if (commit && rw) begin
                asm_q <= full[23:0];
                if (last) data_out <= result;
            end
        end
    end
    assign bus.DataOut   = data_out;
    assign bus.MOC       = state == DONE;
    assign bus.Err       = state == DONE && err;
    assign bus.Busy      = state != IDLE;
    assign bus.ram_cs    = act;
    assign bus.ram_we    = act && !rw;
    assign bus.ram_addr  = act ? addr + ADDR_W'(k) : '0;
    assign bus.ram_wdata = act && !rw ? wbyte : '0;
endmodule

// File: tb/tb_memory_access_controller.sv
// tb_memory_access_controller: directed vector table, abort sequence and random requests checked
// against a byte-array RAM model computed from the request semantics.
module tb_memory_access_controller;
    localparam int W = 2;
    typedef struct {
        logic        rw;
        logic [1:0]  t;
        logic        s;
        logic [8:0]  a;
        logic [31:0] d;
        int          keep;
        logic [31:0] ed;
        logic        ee;
        int          el;
    } vec_t;
    logic        Clk = 0, Clr = 1, pl_en = 1;
    int          checks = 0, failures = 0, we_bad = 0;
    logic [7:0]  mem [512];
    logic [7:0]  ref_mem [512];
    logic [31:0] cur_dout;
    memory_access_controller_if #(.ADDR_W(9)) bus ();
    memory_access_controller #(.ADDR_W(9), .WAIT_CYCLES(W)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));
    always #5 Clk = ~Clk;
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge Clk) begin
        if (pl_en) for (int i = 0; i < 512; i++) mem[i] <= ref_mem[i];
        else if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
    always @(negedge Clk) if (bus.ram_we && !bus.ram_cs) we_bad++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] t);
        return t == 2'd0 ? 1 : t == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] t, input logic [8:0] a);
        return t == 2'd3 || (t == 2'd1 && a % 2 != 0) || (t == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_read(input logic [8:0] a, input logic [1:0] t, input logic s);
        int n;
        logic [31:0] v;
        n = nbytes(t);
        v = 0;
        for (int i = 0; i < n; i++) v = v * 256 + 32'(ref_mem[(int'(a) + i) % 512]);
        if (s && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_write(input logic [8:0] a, input logic [1:0] t, input logic [31:0] d);
        int n;
        n = nbytes(t);
        for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 512] = 8'(d >> (8 * (n - 1 - i)));
    endtask

    task automatic ram_check(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(nm, 64'(bad), 64'd0);
    endtask

    task automatic run_req(input logic rw, input logic [1:0] t, input logic s, input logic [8:0] a,
                           input logic [31:0] d, input int keep, input logic [31:0] ed, input logic ee,
                           input int el, input string nm);
        int n, cs, nb, j, bus_bad;
        logic got;
        nb = nbytes(t);
        n = 0; cs = 0; bus_bad = 0; got = 0;
        @(negedge Clk);
        bus.MOV = 1; bus.RW = rw; bus.Type = t; bus.Sign = s; bus.Addr = a; bus.DataIn = d;
        while (!got && n < 200) begin
            @(negedge Clk);
            n++;
            if (n == 1) begin
                if (keep == 0) bus.MOV = 0;
                bus.RW = 1'($urandom); bus.Type = 2'($urandom); bus.Sign = 1'($urandom);
                bus.Addr = 9'($urandom); bus.DataIn = $urandom;
            end
            if (bus.MOC) got = 1;
            else if (bus.ram_cs) begin
                j = cs / (W + 1);
                cs++;
                if (bus.ram_addr != 9'(int'(a) + j) || bus.ram_we != !rw ||
                    (!rw && bus.ram_wdata != 8'(d >> (8 * (nb - 1 - j))))) bus_bad++;
            end
        end
        check({nm, " latency"}, got ? 64'(n - 1) : 64'hFFFF, 64'(el));
        check({nm, " data"}, 64'(bus.DataOut), 64'(ed));
        check({nm, " err"}, 64'(bus.Err), 64'(ee));
        check({nm, " busy"}, 64'(bus.Busy), 64'd1);
        check({nm, " cs cycles"}, 64'(cs), ee ? 64'd0 : 64'(nb * (W + 1)));
        check({nm, " ram port"}, 64'(bus_bad), 64'd0);
        for (int i = 0; i < keep; i++) begin
            @(negedge Clk);
            check({nm, " moc hold"}, 64'({bus.MOC, bus.Err}), 64'({1'b1, ee}));
        end
        bus.MOV = 0;
        @(negedge Clk);
        check({nm, " release"}, 64'({bus.MOC, bus.Err, bus.Busy}), 64'd0);
        ram_check({nm, " ram"});
    endtask

    initial begin
        vec_t tbl[14];
        logic moc_seen;
        bus.MOV = 0; bus.RW = 0; bus.Type = 0; bus.Sign = 0; bus.Addr = 0; bus.DataIn = 0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
        ref_mem[9'h010] = 8'h12; ref_mem[9'h011] = 8'h34; ref_mem[9'h012] = 8'h56; ref_mem[9'h013] = 8'h78;
        ref_mem[9'h021] = 8'h9C;
        tbl[0]  = '{1, 2'b10, 0, 9'h010, 32'h0,        0, 32'h12345678, 0, 12};
        tbl[1]  = '{1, 2'b00, 1, 9'h021, 32'h0,        0, 32'hFFFFFF9C, 0, 3};
        tbl[2]  = '{1, 2'b00, 0, 9'h021, 32'h0,        0, 32'h0000009C, 0, 3};
        tbl[3]  = '{0, 2'b01, 0, 9'h040, 32'hAABBCCDD, 0, 32'h0000009C, 0, 6};
        tbl[4]  = '{1, 2'b10, 0, 9'h006, 32'h0,        0, 32'h0000009C, 1, 1};
        tbl[5]  = '{1, 2'b10, 0, 9'h010, 32'h0,        5, 32'h12345678, 0, 12};
        tbl[6]  = '{1, 2'b01, 1, 9'h040, 32'h0,        0, 32'hFFFFCCDD, 0, 6};
        tbl[7]  = '{1, 2'b01, 0, 9'h040, 32'h0,        2, 32'h0000CCDD, 0, 6};
        tbl[8]  = '{0, 2'b11, 0, 9'h000, 32'h12345678, 0, 32'h0000CCDD, 1, 1};
        tbl[9]  = '{1, 2'b01, 0, 9'h041, 32'h0,        3, 32'h0000CCDD, 1, 1};
        tbl[10] = '{0, 2'b10, 0, 9'h1FC, 32'hDEADBEEF, 0, 32'h0000CCDD, 0, 12};
        tbl[11] = '{1, 2'b10, 1, 9'h1FC, 32'h0,        0, 32'hDEADBEEF, 0, 12};
        tbl[12] = '{0, 2'b00, 0, 9'h1FF, 32'h000000A5, 0, 32'hDEADBEEF, 0, 3};
        tbl[13] = '{1, 2'b00, 1, 9'h1FF, 32'h0,        0, 32'hFFFFFFA5, 0, 3};
        repeat (2) @(negedge Clk);
        check("reset outputs", {bus.DataOut, bus.MOC, bus.Err, bus.Busy, bus.ram_cs, bus.ram_we,
                                bus.ram_addr, bus.ram_wdata}, 64'd0);
        Clr = 0; pl_en = 0;
        foreach (tbl[i]) begin
            if (!tbl[i].rw && !tbl[i].ee) model_write(tbl[i].a, tbl[i].t, tbl[i].d);
            run_req(tbl[i].rw, tbl[i].t, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].keep,
                    tbl[i].ed, tbl[i].ee, tbl[i].el, $sformatf("vec%0d", i));
        end
        // Abort a word write on the edge that would commit byte 1; bytes 2..3 must never be touched.
        moc_seen = 0;
        @(negedge Clk);
        bus.MOV = 1; bus.RW = 0; bus.Type = 2'b10; bus.Sign = 0; bus.Addr = 9'h080; bus.DataIn = 32'h11223344;
        for (int n = 1; n <= 6; n++) begin
            @(negedge Clk);
            if (n == 1) bus.MOV = 0;
            if (bus.MOC) moc_seen = 1;
        end
        Clr = 1;
        @(negedge Clk);
        check("abort outputs", {bus.DataOut, bus.MOC, bus.Err, bus.Busy, bus.ram_cs, bus.ram_we,
                                bus.ram_addr, bus.ram_wdata}, 64'd0);
        check("abort no moc", 64'(moc_seen), 64'd0);
        Clr = 0;
        ref_mem[9'h080] = 8'h11; ref_mem[9'h081] = 8'h22;
        ram_check("abort ram");
        @(negedge Clk);
        check("abort idle", 64'({bus.MOC, bus.Busy, bus.ram_cs}), 64'd0);
        cur_dout = 0;
        for (int r = 0; r < 40; r++) begin
            logic rw2, s2, e2;
            logic [1:0] t2;
            logic [8:0] a2;
            logic [31:0] d2;
            rw2 = 1'($urandom); s2 = 1'($urandom); t2 = 2'($urandom_range(0, 3));
            a2 = 9'($urandom_range(0, 511)); d2 = $urandom;
            if ($urandom_range(0, 3) != 0) a2[1:0] = 2'b00;
            e2 = model_err(t2, a2);
            if (!e2 && rw2) cur_dout = model_read(a2, t2, s2);
            if (!e2 && !rw2) model_write(a2, t2, d2);
            run_req(rw2, t2, s2, a2, d2, $urandom_range(0, 2), cur_dout, e2,
                    e2 ? 1 : nbytes(t2) * (W + 1), $sformatf("rnd%0d", r));
        end
        check("ram_we without ram_cs", 64'(we_bad), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
